// File: rtl/aukv_gpr_wb_arbiter.sv
// aukv_gpr_wb_arbiter: round-robin write-back arbiter for the GPR write port plus
// per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module aukv_gpr_wb_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_iss_valid,
   input  logic [4:0]      i_iss_rd,
   input  logic            i_iss_rd_en,
   input  logic [4:0]      i_iss_rs1,
   input  logic [4:0]      i_iss_rs2,
   input  logic            i_iss_rs1_en,
   input  logic            i_iss_rs2_en,
   output logic            o_iss_ready,
   input  logic            i_a_valid,
   input  logic [4:0]      i_a_rd,
   input  logic [XLEN-1:0] i_a_data,
   output logic            o_a_ready,
   input  logic            i_b_valid,
   input  logic [4:0]      i_b_rd,
   input  logic [XLEN-1:0] i_b_data,
   output logic            o_b_ready,
   output logic            o_we,
   output logic [4:0]      o_rd_addr,
   output logic [XLEN-1:0] o_data,
   output logic [31:0]     o_busy
);
   logic [31:0]     busy, busy_set, busy_clr;
   logic            r_last, gnt_a, gnt_b, fire;
   logic [4:0]      g_rd;
   logic [XLEN-1:0] g_data;

   always_comb begin
      o_iss_ready = !(i_iss_rs1_en && busy[i_iss_rs1]) && !(i_iss_rs2_en && busy[i_iss_rs2]) &&
                    !(i_iss_rd_en && (i_iss_rd != 5'd0) && busy[i_iss_rd]);
      gnt_a       = i_a_valid && (!i_b_valid || r_last);
      gnt_b       = i_b_valid && (!i_a_valid || !r_last);
      fire        = i_iss_valid && o_iss_ready && i_iss_rd_en && (i_iss_rd != 5'd0);
      busy_set    = fire ? 32'd1 << i_iss_rd : 32'd0;
      busy_clr    = o_we ? 32'd1 << o_rd_addr : 32'd0;
      g_rd        = gnt_b ? i_b_rd : i_a_rd;
      g_data      = gnt_b ? i_b_data : i_a_data;
   end

   assign o_a_ready = gnt_a;
   assign o_b_ready = gnt_b;
   assign o_busy    = busy;

   // set is applied after clear so a same-edge issue keeps the register busy
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         busy      <= '0;
         r_last    <= 1'b1;
         o_we      <= 1'b0;
         o_rd_addr <= '0;
         o_data    <= '0;
      end else begin
         busy <= ((busy & ~busy_clr) | busy_set) & ~32'd1;
         o_we <= (gnt_a || gnt_b) && (g_rd != 5'd0);
         if (gnt_a || gnt_b) begin
            r_last    <= gnt_b;
            o_rd_addr <= g_rd;
            o_data    <= g_data;
         end
      end
   end
endmodule

// File: tb/tb_aukv_gpr_wb_arbiter.sv
// tb_aukv_gpr_wb_arbiter: directed test-plan scenarios plus randomized traffic
// checked against a behavioural model of scoreboard, arbiter and write stage.
module tb_aukv_gpr_wb_arbiter;
   logic        clk = 0, rstn = 0;
   logic        iss_valid, iss_rd_en, iss_rs1_en, iss_rs2_en, iss_ready;
   logic [4:0]  iss_rd, iss_rs1, iss_rs2, a_rd, b_rd, rd_addr;
   logic        a_valid, b_valid, a_ready, b_ready, we;
   logic [31:0] a_data, b_data, data, busy, bsave;
   int          n_chk = 0, n_fail = 0;
   bit          m_busy[32];
   bit          m_last, m_we, last_ga, last_gb;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   always #5 clk = ~clk;

   aukv_gpr_wb_arbiter #(.XLEN(32)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_iss_valid(iss_valid), .i_iss_rd(iss_rd), .i_iss_rd_en(iss_rd_en),
      .i_iss_rs1(iss_rs1), .i_iss_rs2(iss_rs2), .i_iss_rs1_en(iss_rs1_en), .i_iss_rs2_en(iss_rs2_en),
      .o_iss_ready(iss_ready),
      .i_a_valid(a_valid), .i_a_rd(a_rd), .i_a_data(a_data), .o_a_ready(a_ready),
      .i_b_valid(b_valid), .i_b_rd(b_rd), .i_b_data(b_data), .o_b_ready(b_ready),
      .o_we(we), .o_rd_addr(rd_addr), .o_data(data), .o_busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 0;
      m_last = 1; m_we = 0; m_addr = 0; m_data = 0;
   endtask

   function automatic bit model_ready();
      if (iss_rs1_en && m_busy[iss_rs1]) return 0;
      if (iss_rs2_en && m_busy[iss_rs2]) return 0;
      if (iss_rd_en && iss_rd != 0 && m_busy[iss_rd]) return 0;
      return 1;
   endfunction

   function automatic logic [31:0] model_busy_vec();
      logic [31:0] v = '0;
      foreach (m_busy[i]) v[i] = m_busy[i];
      return v;
   endfunction

   task automatic idle_inputs();
      iss_valid = 0; iss_rd = 0; iss_rd_en = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rs1_en = 0; iss_rs2_en = 0;
      a_valid = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0;
   endtask

   // Inputs are applied near the falling edge; check everything, then advance one cycle.
   task automatic tick();
      bit rdy, ga, gb;
      #1;
      rdy = model_ready();
      if (a_valid && b_valid) begin
         ga = m_last;
         gb = !m_last;
      end else begin
         ga = a_valid;
         gb = b_valid;
      end
      chk("iss_ready", iss_ready, rdy);
      chk("a_ready", a_ready, ga);
      chk("b_ready", b_ready, gb);
      chk("we", we, m_we);
      chk("rd_addr", rd_addr, m_addr);
      chk("data", data, m_data);
      chk("busy", busy, model_busy_vec());
      last_ga = ga; last_gb = gb;
      if (m_we) m_busy[m_addr] = 0;
      if (iss_valid && rdy && iss_rd_en && iss_rd != 0) m_busy[iss_rd] = 1;
      if (ga || gb) begin
         m_last = gb;
         m_addr = gb ? b_rd : a_rd;
         m_data = gb ? b_data : a_data;
         m_we   = m_addr != 0;
      end else m_we = 0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle_inputs();
      rstn = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rstn = 1;
   endtask

   initial begin
      last_ga = 0; last_gb = 0;
      do_reset();
      // contention from reset: strict A,B,A,B alternation
      a_valid = 1; a_rd = 1; a_data = 32'h11;
      b_valid = 1; b_rd = 2; b_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("cont_a_ready", a_ready, (i % 2) == 0);
         chk("cont_b_ready", b_ready, (i % 2) == 1);
         if (i > 0) chk("cont_addr", rd_addr, (i % 2) == 0 ? 2 : 1);
         tick();
      end
      idle_inputs();
      #1 chk("cont_addr_last", rd_addr, 2);
      tick();
      // RAW stall and write-back latency
      iss_valid = 1; iss_rd = 5; iss_rd_en = 1;
      tick();
      iss_rd_en = 0; iss_rs1 = 5; iss_rs1_en = 1;
      a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
      #1 chk("raw_stall", iss_ready, 0);
      chk("raw_a_ready", a_ready, 1);
      tick();
      a_valid = 0;
      #1 chk("raw_we", we, 1);
      chk("raw_addr", rd_addr, 5);
      chk("raw_data", data, 32'hDEADBEEF);
      chk("raw_still_stalled", iss_ready, 0);
      tick();
      #1 chk("raw_ready", iss_ready, 1);
      chk("raw_busy5", busy[5], 0);
      tick();
      idle_inputs();
      // write-back and issue to x0
      b_valid = 1; b_rd = 0; b_data = 32'hFFFFFFFF;
      #1 chk("x0_b_ready", b_ready, 1);
      bsave = busy;
      tick();
      b_valid = 0;
      #1 chk("x0_we", we, 0);
      chk("x0_busy", busy, bsave);
      iss_valid = 1; iss_rd = 0; iss_rd_en = 1;
      tick();
      #1 chk("x0_busy0", busy[0], 0);
      // WAW: commit and new issue to busy r7 in the same cycle
      iss_rd = 7;
      tick();
      iss_valid = 0;
      a_valid = 1; a_rd = 7; a_data = 32'h77;
      tick();
      a_valid = 0; iss_valid = 1;
      #1 chk("waw_we", we, 1);
      chk("waw_stall", iss_ready, 0);
      tick();
      #1 chk("waw_ready", iss_ready, 1);
      tick();
      iss_valid = 0;
      #1 chk("waw_busy7", busy[7], 1);
      a_valid = 1;
      tick();
      a_valid = 0;
      tick();
      #1 chk("waw_busy7_clr", busy[7], 0);
      // commit to non-busy r7 on the same edge an issue sets it
      a_valid = 1; a_data = 32'h78;
      tick();
      a_valid = 0; iss_valid = 1; iss_rd = 7; iss_rd_en = 1;
      #1 chk("same_edge_we", we, 1);
      chk("same_edge_ready", iss_ready, 1);
      tick();
      idle_inputs();
      #1 chk("same_edge_busy7", busy[7], 1);
      // async reset mid-operation with busy=0xF0 and a pending write
      do_reset();
      for (int r = 4; r < 8; r++) begin
         iss_valid = 1; iss_rd = 5'(r); iss_rd_en = 1;
         tick();
      end
      idle_inputs();
      a_valid = 1; a_rd = 4; a_data = 32'hCAFE;
      tick();
      idle_inputs();
      iss_valid = 1; iss_rd = 5; iss_rd_en = 1;
      #2 chk("pre_rst_busy", busy, 32'h000000F0);
      chk("pre_rst_we", we, 1);
      chk("pre_rst_ready", iss_ready, 0);
      rstn = 0;
      #1 chk("rst_busy", busy, 0);
      chk("rst_we", we, 0);
      chk("rst_ready", iss_ready, 1);
      model_reset();
      @(negedge clk);
      idle_inputs();
      rstn = 1;
      // randomized traffic; a port that lost arbitration keeps its request stable
      last_ga = 0; last_gb = 0;
      for (int c = 0; c < 3000; c++) begin
         iss_valid = 1'($urandom_range(0, 1));
         iss_rd = 5'($urandom_range(0, 7)); iss_rd_en = 1'($urandom_range(0, 1));
         iss_rs1 = 5'($urandom_range(0, 7)); iss_rs1_en = 1'($urandom_range(0, 1));
         iss_rs2 = 5'($urandom_range(0, 7)); iss_rs2_en = 1'($urandom_range(0, 1));
         if (!a_valid || last_ga) begin
            a_valid = 1'($urandom_range(0, 1)); a_rd = 5'($urandom_range(0, 7)); a_data = $urandom;
         end
         if (!b_valid || last_gb) begin
            b_valid = 1'($urandom_range(0, 1)); b_rd = 5'($urandom_range(0, 7)); b_data = $urandom;
         end
         tick();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
